// File: rtl/vec_pkg.sv
// Shared types and constants for the vector program loader.
package vec_pkg;

    // 32-bit words making up one 128-bit instruction
    localparam int unsigned INST_WORDS = 4;

    // Header word layout: instruction count in the upper half, vector count in the lower half
    localparam int unsigned HDR_INST_MSB = 31;
    localparam int unsigned HDR_INST_LSB = 16;
    localparam int unsigned HDR_DATA_MSB = 15;
    localparam int unsigned HDR_DATA_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_INST,
        LOAD_DATA,
        RUN,
        DRAIN
    } VecLoaderState_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/vec_word_packer.sv
// Collects N consecutive 32-bit words into one wide word; word k lands in bits [32k+31:32k].
module vec_word_packer #(
    parameter int unsigned N = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            valid_i,
    input  logic [31:0]     data_i,
    output logic [32*N-1:0] data_o,
    output logic            done_o,
    output logic            last_o
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0]   cnt_q;
    logic [32*N-1:0] buf_q;
    logic            done_q;

    // Word slots are written in place, so the buffer is valid while the next group starts filling
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q  <= '0;
            buf_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (valid_i) begin
                buf_q[32*cnt_q +: 32] <= data_i;
                if (last_o) begin
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign last_o = (cnt_q == CW'(N - 1));
    assign data_o = buf_q;
    assign done_o = done_q;

endmodule

// File: rtl/vec_prog_loader.sv
// Host-side loader: unpacks a header plus instruction/vector words into memory,
// runs the core with cycle counting, then streams the loaded vectors back out.
module vec_prog_loader
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH              = 16,
    parameter int unsigned INST_MEM_SIZE      = 2048,
    parameter int unsigned DATA_MEM_SIZE      = 2048,
    parameter int unsigned INST_MEM_ADDR_SIZE = 32,
    parameter int unsigned DATA_MEM_ADDR_SIZE = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic                          inst_write_en,
    output logic [INST_MEM_ADDR_SIZE-1:0] inst_write_addr,
    output logic [32*INST_WORDS-1:0]      inst_write_data,
    output logic                          data_write_en,
    output logic [DATA_MEM_ADDR_SIZE-1:0] data_write_addr,
    output logic [32*WIDTH-1:0]           data_write_data,
    output logic [DATA_MEM_ADDR_SIZE-1:0] data_read_addr,
    input  logic [32*WIDTH-1:0]           data_read_data,
    output logic                          core_reset,
    input  logic                          core_done,
    output logic                          busy,
    output logic                          err,
    output logic [31:0]                   run_cycles
);

    localparam int unsigned IC_W   = $clog2(INST_MEM_SIZE + 1);
    localparam int unsigned DC_W   = $clog2(DATA_MEM_SIZE + 1);
    localparam int unsigned LANE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    VecLoaderState_t state_q;

    logic              in_ready_q;
    logic              out_valid_q;
    logic              core_reset_q;
    logic              err_q;
    logic [31:0]       run_cycles_q;
    logic [31:0]       run_cycles_d;

    logic [IC_W-1:0]   inst_count_q;
    logic [IC_W-1:0]   inst_coll_q;
    logic [IC_W-1:0]   inst_idx_q;
    logic [DC_W-1:0]   data_count_q;
    logic [DC_W-1:0]   data_coll_q;
    logic [DC_W-1:0]   data_idx_q;
    logic [DC_W-1:0]   drain_vec_q;
    logic [LANE_W-1:0] lane_q;

    logic              accept;
    logic [15:0]       hdr_inst;
    logic [15:0]       hdr_data;
    logic              hdr_bad;

    logic              inst_pk_valid;
    logic              inst_pk_done;
    logic              inst_pk_last;
    logic              data_pk_valid;
    logic              data_pk_done;
    logic              data_pk_last;
    logic              pk_clear;

    logic              inst_last_accept;
    logic              inst_final_write;
    logic              data_last_accept;
    logic              data_final_write;
    logic              out_fire;
    logic              lane_last;

    assign accept   = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    assign hdr_inst = in_data[HDR_INST_MSB:HDR_INST_LSB];
    assign hdr_data = in_data[HDR_DATA_MSB:HDR_DATA_LSB];
    assign hdr_bad  = (32'(hdr_inst) > INST_MEM_SIZE) || (32'(hdr_data) > DATA_MEM_SIZE);

    assign pk_clear      = accept && (state_q == IDLE);
    assign inst_pk_valid = accept && (state_q == LOAD_INST);
    assign data_pk_valid = accept && (state_q == LOAD_DATA);

    // The final word of a phase drops in_ready so no word of the next phase is
    // taken while the last write is still being presented.
    assign inst_last_accept = inst_pk_valid && inst_pk_last && (inst_coll_q == inst_count_q - IC_W'(1));
    assign data_last_accept = data_pk_valid && data_pk_last && (data_coll_q == data_count_q - DC_W'(1));
    assign inst_final_write = inst_pk_done && (inst_idx_q == inst_count_q - IC_W'(1));
    assign data_final_write = data_pk_done && (data_idx_q == data_count_q - DC_W'(1));
    assign lane_last        = (lane_q == LANE_W'(WIDTH - 1));

    vec_word_packer #(
        .N(INST_WORDS)
    ) u_inst_packer (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (pk_clear),
        .valid_i (inst_pk_valid),
        .data_i  (in_data),
        .data_o  (inst_write_data),
        .done_o  (inst_pk_done),
        .last_o  (inst_pk_last)
    );

    vec_word_packer #(
        .N(WIDTH)
    ) u_data_packer (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (pk_clear),
        .valid_i (data_pk_valid),
        .data_i  (in_data),
        .data_o  (data_write_data),
        .done_o  (data_pk_done),
        .last_o  (data_pk_last)
    );

    // Saturating next value of the run-cycle counter
    always_comb begin
        run_cycles_d = sat_inc32(run_cycles_q);
    end

    // Loader sequencing: header decode, load bookkeeping, run timing and drain walk
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            core_reset_q <= 1'b1;
            err_q        <= 1'b0;
            run_cycles_q <= '0;
            inst_count_q <= '0;
            inst_coll_q  <= '0;
            inst_idx_q   <= '0;
            data_count_q <= '0;
            data_coll_q  <= '0;
            data_idx_q   <= '0;
            drain_vec_q  <= '0;
            lane_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (hdr_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q        <= 1'b0;
                            run_cycles_q <= '0;
                            inst_count_q <= IC_W'(hdr_inst);
                            data_count_q <= DC_W'(hdr_data);
                            inst_coll_q  <= '0;
                            inst_idx_q   <= '0;
                            data_coll_q  <= '0;
                            data_idx_q   <= '0;
                            drain_vec_q  <= '0;
                            lane_q       <= '0;
                            if (hdr_inst != 16'd0) begin
                                state_q <= LOAD_INST;
                            end else if (hdr_data != 16'd0) begin
                                state_q <= LOAD_DATA;
                            end else begin
                                state_q      <= RUN;
                                in_ready_q   <= 1'b0;
                                core_reset_q <= 1'b0;
                            end
                        end
                    end
                end

                LOAD_INST: begin
                    if (inst_pk_valid && inst_pk_last) begin
                        inst_coll_q <= inst_coll_q + 1'b1;
                    end
                    if (inst_last_accept) begin
                        in_ready_q <= 1'b0;
                    end
                    if (inst_pk_done) begin
                        inst_idx_q <= inst_idx_q + 1'b1;
                        if (inst_final_write) begin
                            if (data_count_q != '0) begin
                                state_q    <= LOAD_DATA;
                                in_ready_q <= 1'b1;
                            end else begin
                                state_q      <= RUN;
                                core_reset_q <= 1'b0;
                            end
                        end
                    end
                end

                LOAD_DATA: begin
                    if (data_pk_valid && data_pk_last) begin
                        data_coll_q <= data_coll_q + 1'b1;
                    end
                    if (data_last_accept) begin
                        in_ready_q <= 1'b0;
                    end
                    if (data_pk_done) begin
                        data_idx_q <= data_idx_q + 1'b1;
                        if (data_final_write) begin
                            state_q      <= RUN;
                            core_reset_q <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    run_cycles_q <= run_cycles_d;
                    if (core_done) begin
                        core_reset_q <= 1'b1;
                        if (data_count_q != '0) begin
                            state_q     <= DRAIN;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (out_fire) begin
                        if (lane_last) begin
                            lane_q <= '0;
                            if (drain_vec_q == data_count_q - DC_W'(1)) begin
                                state_q     <= IDLE;
                                out_valid_q <= 1'b0;
                                in_ready_q  <= 1'b1;
                            end else begin
                                drain_vec_q <= drain_vec_q + 1'b1;
                            end
                        end else begin
                            lane_q <= lane_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Lane select of the combinational memory read; forced to zero when nothing is offered
    always_comb begin
        out_data = '0;
        if (out_valid_q) begin
            out_data = data_read_data[32*lane_q +: 32];
        end
    end

    // Strobes are gated by reset so an abort cancels a write already in flight
    assign inst_write_en   = inst_pk_done && !reset;
    assign data_write_en   = data_pk_done && !reset;
    assign inst_write_addr = INST_MEM_ADDR_SIZE'(inst_idx_q);
    assign data_write_addr = DATA_MEM_ADDR_SIZE'(data_idx_q);
    assign data_read_addr  = DATA_MEM_ADDR_SIZE'(drain_vec_q);

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign core_reset = core_reset_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_vec_prog_loader.sv
// Scoreboard bench for vec_prog_loader: stimulus pushes expected writes and
// drain words into queues, a negedge monitor pops and compares them.
module tb_vec_prog_loader;

    localparam int unsigned W   = 16;
    localparam int unsigned IMS = 2048;
    localparam int unsigned DMS = 2048;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              inst_write_en;
    logic [31:0]       inst_write_addr;
    logic [127:0]      inst_write_data;
    logic              data_write_en;
    logic [31:0]       data_write_addr;
    logic [32*W-1:0]   data_write_data;
    logic [31:0]       data_read_addr;
    logic [32*W-1:0]   data_read_data;
    logic              core_reset;
    logic              core_done;
    logic              busy;
    logic              err;
    logic [31:0]       run_cycles;

    vec_prog_loader #(
        .WIDTH              (W),
        .INST_MEM_SIZE      (IMS),
        .DATA_MEM_SIZE      (DMS),
        .INST_MEM_ADDR_SIZE (32),
        .DATA_MEM_ADDR_SIZE (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .inst_write_en   (inst_write_en),
        .inst_write_addr (inst_write_addr),
        .inst_write_data (inst_write_data),
        .data_write_en   (data_write_en),
        .data_write_addr (data_write_addr),
        .data_write_data (data_write_data),
        .data_read_addr  (data_read_addr),
        .data_read_data  (data_read_data),
        .core_reset      (core_reset),
        .core_done       (core_done),
        .busy            (busy),
        .err             (err),
        .run_cycles      (run_cycles)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } iw_t;

    typedef struct packed {
        logic [31:0]     addr;
        logic [32*W-1:0] data;
    } dw_t;

    iw_t         inst_exp[$];
    dw_t         data_exp[$];
    logic [31:0] out_exp[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dwr_cyc  = 0;
    bit rnd_rdy  = 1'b0;

    logic [32*W-1:0] mem [0:7];
    logic            prev_stall = 1'b0;
    logic [31:0]     prev_out = '0;
    iw_t             ie;
    dw_t             de;
    logic [31:0]     oe;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] iword(input int unsigned p, input int unsigned i, input int unsigned k);
        return 32'hC000_0000 + 32'(p << 20) + 32'(i << 8) + 32'(k);
    endfunction

    function automatic logic [31:0] dword(input int unsigned p, input int unsigned v, input int unsigned j);
        return 32'hD000_0000 + 32'(p << 20) + 32'(v << 8) + 32'(j);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    assign data_read_data = mem[data_read_addr[2:0]];

    // Host-side result acceptance: always ready, or randomly stalling, changed just after each edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: memory model plus scoreboard comparison of every strobe and result handshake
    always @(negedge clock) begin
        if (inst_write_en) begin
            check("inst_write_expected", 512'(inst_exp.size() != 0), 512'(1));
            if (inst_exp.size() != 0) begin
                ie = inst_exp.pop_front();
                check("inst_write_addr", inst_write_addr, ie.addr);
                check("inst_write_data", inst_write_data, ie.data);
            end
        end
        if (data_write_en) begin
            mem[data_write_addr[2:0]] <= data_write_data;
            dwr_cyc <= cyc;
            check("data_write_expected", 512'(data_exp.size() != 0), 512'(1));
            if (data_exp.size() != 0) begin
                de = data_exp.pop_front();
                check("data_write_addr", data_write_addr, de.addr);
                check("data_write_data", data_write_data, de.data);
            end
        end
        if (prev_stall) begin
            check("out_valid_hold", out_valid, 1);
            check("out_data_hold", out_data, prev_out);
        end
        if (out_valid && out_ready) begin
            check("out_word_expected", 512'(out_exp.size() != 0), 512'(1));
            if (out_exp.size() != 0) begin
                oe = out_exp.pop_front();
                check("out_word", out_data, oe);
            end
        end
        prev_stall <= out_valid && !out_ready;
        prev_out   <= out_data;
    end

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        bit took;
        took = 1'b0;
        if (gap != 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 100 && !took; t++) begin
            took = in_ready;
            @(negedge clock);
        end
        check("in_accept", took, 1);
    endtask

    task automatic send_packet(input int unsigned p, input int unsigned ni, input int unsigned nd,
                               input int unsigned gapmax);
        logic [127:0]    iv;
        logic [32*W-1:0] dv;
        send_word({16'(ni), 16'(nd)}, 0);
        check("err_cleared_by_header", err, 0);
        for (int unsigned i = 0; i < ni; i++) begin
            iv = '0;
            for (int unsigned k = 0; k < 4; k++) iv[32*k +: 32] = iword(p, i, k);
            inst_exp.push_back('{addr: 32'(i), data: iv});
            for (int unsigned k = 0; k < 4; k++)
                send_word(iword(p, i, k), (gapmax == 0) ? 0 : $urandom_range(0, gapmax));
        end
        for (int unsigned v = 0; v < nd; v++) begin
            dv = '0;
            for (int unsigned j = 0; j < W; j++) begin
                dv[32*j +: 32] = dword(p, v, j);
                out_exp.push_back(dword(p, v, j));
            end
            data_exp.push_back('{addr: 32'(v), data: dv});
            for (int unsigned j = 0; j < W; j++)
                send_word(dword(p, v, j), (gapmax == 0) ? 0 : $urandom_range(0, gapmax));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check("return_to_idle", busy, 0);
        check("out_queue_drained", out_exp.size(), 0);
        check("in_ready_in_idle", in_ready, 1);
        check("out_valid_in_idle", out_valid, 0);
    endtask

    task automatic run_and_drain(input int unsigned nd, input int unsigned run_len, input bit chk_release);
        int t;
        t = 0;
        while (core_reset && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("core_release", core_reset, 0);
        if (chk_release) check("release_after_last_write", 32'(cyc - dwr_cyc), 1);
        repeat (run_len - 1) @(negedge clock);
        core_done = 1'b1;
        @(negedge clock);
        core_done = 1'b0;
        check("run_cycles", run_cycles, run_len);
        check("core_reset_reasserted", core_reset, 1);
        check("drain_entry", out_valid, (nd != 0));
        wait_idle();
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_inst_we", inst_write_en, 0);
        check("rst_inst_addr", inst_write_addr, 0);
        check("rst_inst_data", inst_write_data, 0);
        check("rst_data_we", data_write_en, 0);
        check("rst_data_addr", data_write_addr, 0);
        check("rst_data_data", data_write_data, 0);
        check("rst_read_addr", data_read_addr, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_run_cycles", run_cycles, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [127:0] iv;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        core_done = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clock);
        check("idle_in_ready", in_ready, 1);

        // Two instructions and one vector, no stalls, 10-cycle run
        send_packet(1, 2, 1, 0);
        run_and_drain(1, 10, 1);

        // Empty program: straight to RUN, back to IDLE without draining
        send_word(32'h0000_0000, 0);
        in_valid = 1'b0;
        check("empty_core_released", core_reset, 0);
        check("empty_in_ready_low", in_ready, 0);
        check("empty_busy", busy, 1);
        run_and_drain(0, 3, 0);

        // Oversized headers flag err and leave the loader idle
        send_word({16'(IMS + 1), 16'd1}, 0);
        in_valid = 1'b0;
        check("bad_inst_err", err, 1);
        check("bad_inst_busy", busy, 0);
        check("bad_inst_in_ready", in_ready, 1);
        send_word({16'd1, 16'(DMS + 1)}, 0);
        in_valid = 1'b0;
        check("bad_data_err", err, 1);
        repeat (3) @(negedge clock);
        check("bad_err_sticky", err, 1);
        check("bad_in_ready_stays", in_ready, 1);

        // Valid header clears err; random input gaps and output stalls
        rnd_rdy = 1'b1;
        send_packet(2, 2, 3, 2);
        run_and_drain(3, 4, 1);
        rnd_rdy = 1'b0;

        // Abort in the middle of LOAD_DATA after five vector words
        iv = '0;
        for (int unsigned k = 0; k < 4; k++) iv[32*k +: 32] = iword(5, 0, k);
        inst_exp.push_back('{addr: 32'd0, data: iv});
        send_word(32'h0001_0001, 0);
        for (int unsigned k = 0; k < 4; k++) send_word(iword(5, 0, k), 0);
        for (int unsigned j = 0; j < 5; j++) send_word(dword(5, 0, j), 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clock);
        send_packet(3, 1, 1, 1);
        run_and_drain(1, 2, 1);

        // core_done already high when RUN is entered
        core_done = 1'b1;
        send_packet(4, 0, 1, 0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("early_done_drain", out_valid, 1);
        check("early_done_run_cycles", run_cycles, 1);
        check("early_done_core_reset", core_reset, 1);
        core_done = 1'b0;
        wait_idle();

        check("inst_queue_empty", inst_exp.size(), 0);
        check("data_queue_empty", data_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
